alu_req_arbiter: RTL and testbench
==================================

Name: alu_req_arbiter

Overview:
- Shares the single 4-bit-operand / 8-bit-result ALU datapath between two requesters.
- Accepts operations through valid/ready handshakes and arbitrates round-robin.
- Drives the ALU operand and opcode inputs from registers held stable for ALU_LAT cycles, then samples the ALU result.
- Returns the result and the requester ID on a valid/ready response channel.
- Sits between the command sources (CPU-side sequencer, test harness) and the combinational ALU.

Parameters:
- DATA_W, 4, operand width (r1/r2).
- OP_W, 4, opcode width.
- RES_W, 8, ALU result width.
- ALU_LAT, 1, cycles from operand drive to result sample; legal range 1..15.
- IDLE_OP, 4'b1111, opcode driven to the ALU when no operation is in flight.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester request valid; bit i = requester i.
- req_ready  out  2  per-requester accept; at most one bit high per cycle.
- req_a  in  2*DATA_W  operand A; requester i occupies bits [i*DATA_W +: DATA_W].
- req_b  in  2*DATA_W  operand B; same packing as req_a.
- req_op  in  2*OP_W  opcode; same packing.
- alu_r1  out  DATA_W  operand A to ALU.
- alu_r2  out  DATA_W  operand B to ALU.
- alu_op_code  out  OP_W  opcode to ALU.
- alu_out  in  RES_W  ALU result (combinational from alu_r1/alu_r2/alu_op_code).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  1  requester that issued the op.
- rsp_data  out  RES_W  captured ALU result.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - state=IDLE; rr_ptr=0 (requester 0 has priority first).
  - alu_r1=0, alu_r2=0, alu_op_code=IDLE_OP.
  - rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, req_ready=0, lat_cnt=0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - req_ready is combinational. If only one bit of req_valid is high, that requester gets ready.
  - If both are high, requester rr_ptr wins.
  - Handshake occurs when req_valid[i] && req_ready[i]. On that edge:
    - latch that requester's a/b/op into alu_r1/alu_r2/alu_op_code;
    - rsp_id<=i; rr_ptr<=~i; lat_cnt<=ALU_LAT; state<=EXEC.
  - With no valid request, state stays IDLE and ALU inputs hold IDLE_OP with zero operands.
- EXEC:
  - req_ready=0; ALU inputs held constant.
  - lat_cnt decrements each cycle.
  - On the edge where lat_cnt==1: rsp_data<=alu_out, rsp_valid<=1, state<=RESP.
  - ALU inputs return to 0/0/IDLE_OP on the same edge.
  - Sample latency: with ALU_LAT=1, operands are driven for exactly 1 cycle before sampling.
- RESP:
  - rsp_valid, rsp_id and rsp_data are held stable until rsp_valid && rsp_ready.
  - On that edge: rsp_valid<=0, state<=IDLE.
  - No new request is accepted in RESP; acceptance resumes the cycle after return to IDLE.
- Throughput: one op per ALU_LAT+2 cycles minimum. Request-to-rsp_valid latency is ALU_LAT+1 edges after acceptance.
- Fairness: rr_ptr updates only on an accepted request. A requester holding valid continuously is served within one other transaction.
- Request stability: req_a/b/op of a requester are sampled only on its accept edge. Later changes do not affect the in-flight op.
- rsp_ready high while not in RESP has no effect.
- Reset mid-operation (EXEC or RESP): in-flight op and pending response are discarded, rsp_valid drops immediately, all reset values apply, and no response is emitted after release.
- Arithmetic: the block performs no arithmetic; rsp_data is the full RES_W alu_out bit-exact.

Test Plan:
- Bench ALU model: op 0000 = zero-extended A+B; op 0001 = zero-extended A-B (mod 2^RES_W); other ops give 0.
- Single request: requester 0 sends a=0111, b=0100, op=0000 with rsp_ready=1 -> accepted cycle 0; alu_r1/r2/op=0111/0100/0000 during cycle 1; rsp_valid cycle 2 with rsp_id=0, rsp_data=00001011; busy 0 again from cycle 3.
- Contention after reset: both valid; req0 a=0111,b=0100,op=0000; req1 a=1010,b=0001,op=0001 -> req0 served first (00001011, id 0), then req1 (00001001, id 1). With both still valid, grants then alternate 0,1,0,1.
- Back-pressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid/id/data stable all 5 cycles, req_ready=0, ALU inputs=0/0/1111; one cycle after rsp_ready=1, IDLE accepts the next request.
- ALU_LAT=3 build: alu_op_code held 3 cycles, result sampled on 3rd EXEC edge, rsp_valid 4 edges after accept. Operand change on req_a after accept leaves rsp_data unchanged.
- Async reset: assert rst_n=0 mid-EXEC, between clock edges -> rsp_valid=0, busy=0 and alu_op_code=1111 immediately without a clock edge; no response after release; the next request is served with rr_ptr=0 priority.

Source files
------------

// File: rtl/alu_req_arbiter.sv
// Round-robin front end that shares one combinational ALU between two requesters.
// Each op holds the ALU inputs for ALU_LAT cycles, captures the result and returns it with the requester ID.
module alu_req_arbiter #(
  parameter int              DATA_W  = 4,
  parameter int              OP_W    = 4,
  parameter int              RES_W   = 8,
  parameter int              ALU_LAT = 1,
  parameter logic [OP_W-1:0] IDLE_OP = 4'b1111
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  input  logic [2*OP_W-1:0]   req_op,
  output logic [DATA_W-1:0]   alu_r1,
  output logic [DATA_W-1:0]   alu_r2,
  output logic [OP_W-1:0]     alu_op_code,
  input  logic [RES_W-1:0]    alu_out,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [RES_W-1:0]    rsp_data,
  output logic                busy
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  localparam logic [3:0] LAT_INIT = 4'(ALU_LAT);

  state_t     state;
  state_t     state_nxt;
  logic       rr_ptr;
  logic [3:0] lat_cnt;
  logic       grant_id;
  logic       accept;

  // With both requesters valid the pointer decides; otherwise the lone valid one wins.
  always_comb begin
    grant_id = req_valid[1];
    if (req_valid == 2'b11) grant_id = rr_ptr;
  end

  assign accept = |(req_valid & req_ready);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_EXEC;
      S_EXEC:  if (lat_cnt == 4'd1) state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic; ready is also held low while reset is asserted.
  always_comb begin
    busy      = (state != S_IDLE);
    req_ready = 2'b00;
    if (state == S_IDLE && rst_n && req_valid != 2'b00)
      req_ready = grant_id ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= 1'b0;
      lat_cnt     <= 4'd0;
      alu_r1      <= '0;
      alu_r2      <= '0;
      alu_op_code <= IDLE_OP;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_data    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            alu_r1      <= grant_id ? req_a[2*DATA_W-1:DATA_W] : req_a[DATA_W-1:0];
            alu_r2      <= grant_id ? req_b[2*DATA_W-1:DATA_W] : req_b[DATA_W-1:0];
            alu_op_code <= grant_id ? req_op[2*OP_W-1:OP_W] : req_op[OP_W-1:0];
            rsp_id      <= grant_id;
            rr_ptr      <= ~grant_id;
            lat_cnt     <= LAT_INIT;
          end
        end
        S_EXEC: begin
          lat_cnt <= lat_cnt - 4'd1;
          // Last hold cycle: capture the result and park the ALU inputs.
          if (lat_cnt == 4'd1) begin
            rsp_data    <= alu_out;
            rsp_valid   <= 1'b1;
            alu_r1      <= '0;
            alu_r2      <= '0;
            alu_op_code <= IDLE_OP;
          end
        end
        S_RESP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: vector table, hand sequences (back-pressure, ALU_LAT=3, async reset)
// and random transactions checked against a transaction-level round-robin/ALU model.
module tb_alu_req_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Instance A: ALU_LAT = 1
  logic [1:0] req_valid, req_ready;
  logic [7:0] req_a, req_b, req_op;
  logic [3:0] alu_r1, alu_r2, alu_op_code;
  logic [7:0] alu_out, rsp_data;
  logic       rsp_valid, rsp_ready, rsp_id, busy;

  // Instance B: ALU_LAT = 3
  logic [1:0] b_req_valid, b_req_ready;
  logic [7:0] b_req_a, b_req_b, b_req_op;
  logic [3:0] b_alu_r1, b_alu_r2, b_alu_op_code;
  logic [7:0] b_alu_out, b_rsp_data;
  logic       b_rsp_valid, b_rsp_ready, b_rsp_id, b_busy;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic logic [7:0] alu_ref(input logic [3:0] a, input logic [3:0] b, input logic [3:0] op);
    case (op)
      4'd0:    return 8'(a) + 8'(b);
      4'd1:    return 8'(a) - 8'(b);
      default: return 8'd0;
    endcase
  endfunction

  assign alu_out   = alu_ref(alu_r1, alu_r2, alu_op_code);
  assign b_alu_out = alu_ref(b_alu_r1, b_alu_r2, b_alu_op_code);

  alu_req_arbiter #(.ALU_LAT(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op),
    .alu_r1(alu_r1), .alu_r2(alu_r2), .alu_op_code(alu_op_code), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy)
  );

  alu_req_arbiter #(.ALU_LAT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_a(b_req_a), .req_b(b_req_b), .req_op(b_req_op),
    .alu_r1(b_alu_r1), .alu_r2(b_alu_r2), .alu_op_code(b_alu_op_code), .alu_out(b_alu_out),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id), .rsp_data(b_rsp_data),
    .busy(b_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One full transaction on instance A, started just after a falling edge with the DUT idle.
  // stall = number of RESP cycles with rsp_ready low.
  task automatic run_txn(input logic [1:0] v, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] op, input int stall, input logic eid,
                         input logic [7:0] edata);
    logic [3:0] ea, eb, eo;
    ea = eid ? a[7:4] : a[3:0];
    eb = eid ? b[7:4] : b[3:0];
    eo = eid ? op[7:4] : op[3:0];
    req_valid = v; req_a = a; req_b = b; req_op = op;
    rsp_ready = (stall == 0);
    #1;
    check("grant", req_ready, eid ? 2'b10 : 2'b01);
    check("idle_busy", busy, 1'b0);
    @(negedge clk);
    req_valid = 2'b00; req_a = ~a; req_b = ~b; req_op = ~op;
    #1;
    check("exec_r1", alu_r1, ea);
    check("exec_r2", alu_r2, eb);
    check("exec_op", alu_op_code, eo);
    check("exec_busy", busy, 1'b1);
    check("exec_rsp_valid", rsp_valid, 1'b0);
    @(negedge clk); #1;
    check("rsp_valid", rsp_valid, 1'b1);
    check("rsp_id", rsp_id, eid);
    check("rsp_data", rsp_data, edata);
    check("rsp_alu_op", alu_op_code, 4'hF);
    check("rsp_alu_r1", alu_r1, 4'h0);
    if (stall > 0) begin
      req_valid = 2'b11;
      for (int i = 1; i < stall; i++) begin
        @(negedge clk); #1;
        check("stall_valid", rsp_valid, 1'b1);
        check("stall_id", rsp_id, eid);
        check("stall_data", rsp_data, edata);
        check("stall_ready", req_ready, 2'b00);
        check("stall_alu", {alu_r1, alu_r2, alu_op_code}, 12'h00F);
      end
      req_valid = 2'b00;
      rsp_ready = 1'b1;
    end
    @(negedge clk); #1;
    check("back_idle_busy", busy, 1'b0);
    check("back_idle_rsp", rsp_valid, 1'b0);
    check("back_idle_op", alu_op_code, 4'hF);
  endtask

  typedef struct {
    logic [1:0] v;
    logic [7:0] a, b, op;
    int         stall;
    logic       id;
    logic [7:0] data;
  } vec_t;

  vec_t tbl[10];
  logic model_ptr;
  logic seen;

  initial begin
    tbl[0] = '{2'b11, 8'hA7, 8'h14, 8'h10, 0, 1'b0, 8'h0B};
    tbl[1] = '{2'b11, 8'hA7, 8'h14, 8'h10, 0, 1'b1, 8'h09};
    tbl[2] = '{2'b11, 8'hA7, 8'h14, 8'h10, 1, 1'b0, 8'h0B};
    tbl[3] = '{2'b11, 8'hA7, 8'h14, 8'h10, 0, 1'b1, 8'h09};
    tbl[4] = '{2'b01, 8'h03, 8'h05, 8'h01, 0, 1'b0, 8'hFE};
    tbl[5] = '{2'b10, 8'hF0, 8'hF0, 8'h00, 2, 1'b1, 8'h1E};
    tbl[6] = '{2'b11, 8'h2F, 8'h31, 8'h10, 0, 1'b0, 8'h10};
    tbl[7] = '{2'b01, 8'h00, 8'h00, 8'h07, 5, 1'b0, 8'h00};
    tbl[8] = '{2'b11, 8'h21, 8'h31, 8'h00, 0, 1'b1, 8'h05};
    tbl[9] = '{2'b01, 8'h00, 8'h01, 8'h01, 2, 1'b0, 8'hFF};

    req_valid = 2'b11; req_a = '0; req_b = '0; req_op = '0; rsp_ready = 1'b0;
    b_req_valid = 2'b00; b_req_a = '0; b_req_b = '0; b_req_op = '0; b_rsp_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_ready", req_ready, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rsp_id", rsp_id, 1'b0);
    check("rst_rsp_data", rsp_data, 8'h00);
    check("rst_alu", {alu_r1, alu_r2, alu_op_code}, 12'h00F);
    check("rst_b_busy", b_busy, 1'b0);
    repeat (2) @(negedge clk);
    req_valid = 2'b00;
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("post_rst_idle_op", alu_op_code, 4'hF);

    // Vector table: contention, alternation, single requesters, back-pressure
    for (int i = 0; i < 10; i++)
      run_txn(tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].stall, tbl[i].id, tbl[i].data);

    // ALU_LAT=3 instance: op held three cycles, operand change after accept ignored
    b_req_valid = 2'b10; b_req_a = 8'hA0; b_req_b = 8'h10; b_req_op = 8'h10; b_rsp_ready = 1'b1;
    #1;
    check("b_grant", b_req_ready, 2'b10);
    @(negedge clk);
    b_req_valid = 2'b00; b_req_a = 8'h50;
    #1;
    check("b_exec1_op", b_alu_op_code, 4'h1);
    check("b_exec1_r1", b_alu_r1, 4'hA);
    check("b_exec1_busy", b_busy, 1'b1);
    for (int i = 2; i <= 3; i++) begin
      @(negedge clk); #1;
      check("b_exec_hold_op", b_alu_op_code, 4'h1);
      check("b_exec_hold_r1", b_alu_r1, 4'hA);
      check("b_exec_no_rsp", b_rsp_valid, 1'b0);
    end
    @(negedge clk); #1;
    check("b_rsp_valid", b_rsp_valid, 1'b1);
    check("b_rsp_id", b_rsp_id, 1'b1);
    check("b_rsp_data", b_rsp_data, 8'h09);
    check("b_rsp_op", b_alu_op_code, 4'hF);
    @(negedge clk); #1;
    check("b_idle_busy", b_busy, 1'b0);

    // Async reset in the middle of EXEC; requester 0 accepted so the pointer had moved to 1
    req_valid = 2'b01; req_a = 8'h03; req_b = 8'h02; req_op = 8'h00; rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check("pre_rst_busy", busy, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rsp_valid", rsp_valid, 1'b0);
    check("async_busy", busy, 1'b0);
    check("async_op", alu_op_code, 4'hF);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk); #1;
      if (rsp_valid || busy) seen = 1'b1;
    end
    check("no_rsp_after_rst", seen, 1'b0);
    run_txn(2'b11, 8'hA7, 8'h14, 8'h10, 0, 1'b0, 8'h0B);
    model_ptr = 1'b1;

    // Random transactions against the round-robin / ALU model
    for (int n = 0; n < 40; n++) begin
      logic [1:0] v;
      logic [7:0] a, b, op;
      logic       w;
      int         stall;
      v     = 2'($urandom_range(1, 3));
      a     = 8'($urandom);
      b     = 8'($urandom);
      op    = {2'b00, 2'($urandom), 2'b00, 2'($urandom)};
      stall = $urandom_range(0, 3);
      w     = (v == 2'b11) ? model_ptr : v[1];
      model_ptr = ~w;
      run_txn(v, a, b, op, stall, w,
              alu_ref(w ? a[7:4] : a[3:0], w ? b[7:4] : b[3:0], w ? op[7:4] : op[3:0]));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
